// File: rtl/hazard_issue_ctrl_pkg.sv
// Shared definitions for the hazard-aware fetch/issue sequencer:
// opcodes, field positions, FSM states and the instruction decoder.
package hazard_issue_ctrl_pkg;

    localparam logic [2:0]  OP_R   = 3'b000;
    localparam logic [2:0]  OP_I1  = 3'b001;
    localparam logic [2:0]  OP_I2  = 3'b010;
    localparam logic [2:0]  OP_BR  = 3'b100;

    localparam logic [15:0] NOP_INST = 16'h0000;

    // Field slices of the 16-bit instruction word
    localparam int OP_LSB    = 13;
    localparam int SRC_A_LSB = 0;   // R-type second source
    localparam int SRC_B_LSB = 3;   // R-type first source, I-type source
    localparam int DST_R_LSB = 6;   // R-type destination
    localparam int DST_I_LSB = 0;   // I-type destination
    localparam int REG_W     = 3;

    typedef enum logic [1:0] {
        RUN,
        RAW_STALL,
        BR_WAIT
    } state_t;

    typedef struct packed {
        logic             rd0_en;
        logic [REG_W-1:0] rd0;
        logic             rd1_en;
        logic [REG_W-1:0] rd1;
        logic             wr_en;
        logic [REG_W-1:0] wr;
        logic             is_br;
    } dec_t;

    // Register read/write usage of one instruction word
    function automatic dec_t decode_inst(input logic [15:0] inst);
        dec_t d;
        d     = '0;
        d.rd0 = inst[SRC_A_LSB +: REG_W];
        d.rd1 = inst[SRC_B_LSB +: REG_W];
        case (inst[OP_LSB +: 3])
            OP_R: begin
                d.rd0_en = 1'b1;
                d.rd1_en = 1'b1;
                d.wr_en  = 1'b1;
                d.wr     = inst[DST_R_LSB +: REG_W];
            end
            OP_I1, OP_I2: begin
                d.rd1_en = 1'b1;
                d.wr_en  = 1'b1;
                d.wr     = inst[DST_I_LSB +: REG_W];
            end
            OP_BR:   d.is_br = 1'b1;
            default: d.is_br = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/hazard_issue_ctrl_if.sv
// Instruction-memory, branch-resolution and decode-side signals of the
// issue sequencer. master = sequencer, slave = memory/execute/decode side.
interface hazard_issue_ctrl_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        br_taken;
    logic [7:0]  br_target;
    logic [15:0] id_inst;
    logic        id_valid;

    modport master (
        output imem_addr, id_inst, id_valid,
        input  imem_data, br_taken, br_target
    );

    modport slave (
        input  imem_addr, id_inst, id_valid,
        output imem_data, br_taken, br_target
    );
endinterface

// File: rtl/hazard_issue_ctrl_haz_scoreboard.sv
// Write scoreboard: a shift register of recently issued destinations and a
// parallel compare against the read fields of the instruction being fetched.
// HAZ_FORWARD_EN: only the newest entry is compared, since older results
// reach decode through the forwarding path.
module haz_scoreboard
    import hazard_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             push_valid_i,
    input  logic [REG_W-1:0] push_dest_i,
    input  logic             rd0_en_i,
    input  logic [REG_W-1:0] rd0_addr_i,
    input  logic             rd1_en_i,
    input  logic [REG_W-1:0] rd1_addr_i,
    output logic             hazard_o
);
`ifdef HAZ_FORWARD_EN
    localparam int CMP_N = 1;
`else
    localparam int CMP_N = DEPTH;
`endif

    logic [DEPTH-1:0] vld_q;
    logic [REG_W-1:0] dst_q [DEPTH];
    logic [CMP_N-1:0] hit_d;

    // Shift one slot per unfrozen cycle; head takes the issued write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dst_q[i] <= '0;
        end else if (en_i) begin
            vld_q[0] <= push_valid_i;
            dst_q[0] <= push_dest_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dst_q[i] <= dst_q[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CMP_N; gi++) begin : g_cmp
            assign hit_d[gi] = vld_q[gi] &&
                               ((rd0_en_i && (rd0_addr_i == dst_q[gi])) ||
                                (rd1_en_i && (rd1_addr_i == dst_q[gi])));
        end
    endgenerate

    assign hazard_o = |hit_d;

endmodule

// File: rtl/hazard_issue_ctrl.sv
// Fetch/issue sequencer: issues one instruction per cycle, inserting
// bubbles on RAW hazards and after branches, and redirects the PC on a
// taken branch. Optional macro HAZ_FORWARD_EN shortens RAW stalls to one
// bubble (see haz_scoreboard).
module hazard_issue_ctrl
    import hazard_issue_ctrl_pkg::*;
#(
    parameter int RAW_DEPTH  = 3,
    parameter int BR_BUBBLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_in,
    hazard_issue_ctrl_if.master bus,
    output logic [15:0]         stall_cycles
);
    localparam int BCW = (BR_BUBBLES < 2) ? 1 : $clog2(BR_BUBBLES + 1);

    state_t          state_q;
    logic [7:0]      pc_q;
    logic [15:0]     id_inst_q;
    logic            id_valid_q;
    logic [15:0]     stall_cnt_q;
    logic [BCW-1:0]  bcnt_q;

    dec_t            dec_d;
    logic            hazard_d;
    logic            issue_d;
    logic            push_valid_d;

    assign dec_d        = decode_inst(bus.imem_data);
    assign issue_d      = (state_q != BR_WAIT) && !hazard_d;
    assign push_valid_d = issue_d && dec_d.wr_en;

    haz_scoreboard #(
        .DEPTH (RAW_DEPTH)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (!stall_in),
        .push_valid_i (push_valid_d),
        .push_dest_i  (dec_d.wr),
        .rd0_en_i     (dec_d.rd0_en),
        .rd0_addr_i   (dec_d.rd0),
        .rd1_en_i     (dec_d.rd1_en),
        .rd1_addr_i   (dec_d.rd1),
        .hazard_o     (hazard_d)
    );

    // Issue FSM with registered decode outputs, PC and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= 8'd0;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= 16'd0;
            bcnt_q      <= '0;
        end else if (!stall_in) begin
            if (!issue_d) begin
                id_inst_q  <= NOP_INST;
                id_valid_q <= 1'b0;
                if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            case (state_q)
                RUN, RAW_STALL: begin
                    if (hazard_d) begin
                        state_q <= RAW_STALL;
                    end else begin
                        id_inst_q  <= bus.imem_data;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_q + 8'd1;
                        if (dec_d.is_br) begin
                            bcnt_q  <= BCW'(BR_BUBBLES);
                            state_q <= BR_WAIT;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                BR_WAIT: begin
                    // Branch outcome is only trusted on the last bubble
                    if (bcnt_q == BCW'(1)) begin
                        if (bus.br_taken) pc_q <= bus.br_target;
                        state_q <= RUN;
                    end else begin
                        bcnt_q <= bcnt_q - BCW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_valid  = id_valid_q;
    assign stall_cycles  = stall_cnt_q;

endmodule

// File: doc/hazard_issue_ctrl.md
Name: hazard_issue_ctrl

Overview:
- Dynamic fetch/issue sequencer for the 16-bit pipelined core. Replaces static NOP padding in instruction memory.
- Drives the 8-bit instruction-memory address and reads the combinational 16-bit instruction back. Issues one instruction per cycle to decode.
- Inserts bubbles on RAW hazards using a short write scoreboard, and after branches; redirects the PC on a taken branch.

Parameters:
- RAW_DEPTH, 3, number of issue slots a register write stays hazardous; also the scoreboard depth.
- BR_BUBBLES, 2, bubbles issued after a branch before the PC redirect decision.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_in  in  1  external freeze; holds all state.
- imem_addr  out  8  instruction-memory address (PC).
- imem_data  in  16  instruction at imem_addr, combinational.
- br_taken  in  1  branch outcome from execute; sampled only on the last branch bubble.
- br_target  in  8  branch target; sampled with br_taken.
- id_inst  out  16  instruction to decode; 16'h0000 during bubbles.
- id_valid  out  1  1 = real instruction, 0 = bubble.
- stall_cycles  out  16  count of bubble cycles; saturates at 16'hFFFF.

Behaviour:
- Decode of imem_data, with op = [15:13]:
  - op 000 (R-type): reads [2:0] and [5:3]; writes [8:6].
  - op 001/010 (I-type): reads [5:3]; writes [2:0].
  - op 100 (branch): no reads, no writes.
  - All other opcodes: no reads, no writes; passed through unchanged.
- Reset (async, rst_n=0):
  - imem_addr=0, id_inst=0, id_valid=0, stall_cycles=0.
  - All scoreboard entries invalid; state=RUN.
- Scoreboard: shift register of RAW_DEPTH entries {valid, dest[2:0]}.
  - Shifts by one every non-frozen cycle.
  - Head loaded with the issued instruction's dest; valid=1 only if that instruction writes.
  - Bubbles load valid=0.
  - Hazard = any read field of imem_data equals the dest of any valid entry.
- State machine (all transitions gated by stall_in=0):
  - RUN, hazard: issue bubble, hold PC, go to RAW_STALL.
  - RUN, no hazard: issue imem_data (id_valid=1), PC+1. If the issued op is 100, load bubble counter=BR_BUBBLES and go to BR_WAIT.
  - RAW_STALL: re-evaluate the hazard every cycle.
    - While the hazard persists: issue bubble, hold PC.
    - When it clears: issue the instruction, PC+1, then apply the same branch check as RUN (go to RUN or BR_WAIT).
  - BR_WAIT: issue a bubble each cycle; PC held at branch address+1; counter decrements.
    - On the cycle the counter reaches 1: if br_taken, PC<=br_target, else PC unchanged. Go to RUN.
- Latency: an instruction at address A appears on id_inst one cycle after imem_addr==A with no hazard.
- Distance-1 dependency costs RAW_DEPTH bubbles; distance-2 costs RAW_DEPTH-1; and so on.
- stall_in=1: all registers hold, including id_inst/id_valid, the scoreboard and the counter. stall_cycles does not increment. stall_in has priority over br_taken sampling; sampling is deferred to the first unfrozen last-bubble cycle.
- PC arithmetic is 8-bit modulo: 255+1 wraps to 0.
- stall_cycles increments on every unfrozen cycle with id_valid=0 after reset; it holds at 16'hFFFF.
- Write-then-read of r0 is treated as a normal hazard; there is no hardwired zero.
- Reset mid-operation, including mid-BR_WAIT: immediate return to the reset values; the pending branch is discarded.

Optional Feature:
- Macro: HAZ_FORWARD_EN.
- Defined: the scoreboard hazard check uses only the head entry, and any match costs exactly 1 bubble (the forwarding path covers the rest). Branch handling is unchanged.
- Undefined: full RAW_DEPTH scoreboard as above.

Decomposition:
- Shared package:
  - Opcode constants: OP_R=3'b000, OP_I1=3'b001, OP_I2=3'b010, OP_BR=3'b100.
  - NOP_INST=16'h0000.
  - State enum {RUN, RAW_STALL, BR_WAIT}.
  - Field-slice localparams for the source and destination fields.
- Sub-module: haz_scoreboard, holding the shift register and the parallel compare.
  - Inputs: push valid/dest, up to two read addresses with enables.
  - Output: hazard.

Test Plan:
- Reset, then R-type 16'h0048 at 0 (writes r1) and R-type reading r1 via [2:0] at 1 -> id_inst: 0048, then 3 bubbles, then the second instruction. stall_cycles=3.
- Writer at 0, independent instruction at 1, reader of the same register at 2 -> exactly 2 bubbles before the address-2 instruction.
- Branch at address 5 with br_taken=1, br_target=8'h20 on the 2nd bubble -> 2 bubbles, then imem_addr=8'h20. With br_taken=0 -> imem_addr=6.
- Straight-line code with no hazards from address 254 -> imem_addr sequence 254, 255, 0, 1; id_valid stays 1.
- stall_in=1 for 4 cycles during RAW_STALL -> outputs frozen and stall_cycles unchanged; after release the remaining bubble count is unchanged.
- rst_n pulsed low mid-BR_WAIT -> imem_addr=0, id_valid=0 asynchronously; no redirect occurs. With HAZ_FORWARD_EN, the first scenario gives 1 bubble.
